// File: rtl/core_decode_stage_pkg.sv
// Shared constants for the 101core decode stage: ALU opcode encodings and RV32I fields.
package core101_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

endpackage

// File: rtl/core_decode_stage_if.sv
// Instruction-in / ALU-op-out handshake plus writeback port of the decode stage.
interface core_decode_stage_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALU_OP_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     alu_operand_a;
  logic [XLEN-1:0]     alu_operand_b;
  logic [ALU_OP_W-1:0] alu_opcode;
  logic [4:0]          out_rd_addr;
  logic                out_rd_we;
  logic                out_illegal;
  logic                wb_en;
  logic [4:0]          wb_addr;
  logic [XLEN-1:0]     wb_data;

  modport master (
    output in_valid, in_instr, flush, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, alu_operand_a, alu_operand_b, alu_opcode,
           out_rd_addr, out_rd_we, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, alu_operand_a, alu_operand_b, alu_opcode,
           out_rd_addr, out_rd_we, out_illegal
  );
endinterface

// File: rtl/core_regfile.sv
// 32-entry register file: two async reads, one sync write, x0 hardwired to zero.
// Define DECODE_BYPASS_EN to forward a same-cycle write onto matching read ports.
module core_regfile #(
  parameter int unsigned Width   = 32,
  parameter int unsigned ResetEn = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       raddr_a_i,
  input  logic [4:0]       raddr_b_i,
  output logic [Width-1:0] rdata_a_o,
  output logic [Width-1:0] rdata_b_o,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [Width-1:0] wdata_i
);

  logic [Width-1:0] mem_q [32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (ResetEn != 0) begin
        for (int i = 0; i < 32; i++) begin
          mem_q[i] <= '0;
        end
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = (raddr_a_i == 5'd0) ? '0 : mem_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == 5'd0) ? '0 : mem_q[raddr_b_i];
`ifdef DECODE_BYPASS_EN
    if (we_i && (waddr_i != 5'd0) && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (we_i && (waddr_i != 5'd0) && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
`endif
  end

endmodule

// File: rtl/core_decode_stage.sv
// RV32I OP/OP-IMM/LUI decode and operand issue into a single-entry ALU pipeline register.
// Optional DECODE_BYPASS_EN (in core_regfile) forwards same-cycle writeback into operands.
module core_decode_stage #(
  parameter int unsigned XLEN          = core101_pkg::XLEN,
  parameter int unsigned ALU_OP_W      = 4,
  parameter int unsigned REGFILE_RESET = 1
) (
  input logic                CLOCK_50,
  input logic                RESET,
  core_decode_stage_if.slave bus
);
  import core101_pkg::*;

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;

  assign instr = bus.in_instr;
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];

  logic [XLEN-1:0] rs1_data, rs2_data;

  core_regfile #(
    .Width   (XLEN),
    .ResetEn (REGFILE_RESET)
  ) u_regfile (
    .clk_i     (CLOCK_50),
    .rst_i     (RESET),
    .raddr_a_i (instr[19:15]),
    .raddr_b_i (instr[24:20]),
    .rdata_a_o (rs1_data),
    .rdata_b_o (rs2_data),
    .we_i      (bus.wb_en),
    .waddr_i   (bus.wb_addr),
    .wdata_i   (bus.wb_data)
  );

  logic [XLEN-1:0]     dec_a, dec_b;
  logic [ALU_OP_W-1:0] dec_op;
  logic                dec_ill;
  logic                dec_we;

  always_comb begin
    dec_a   = '0;
    dec_b   = '0;
    dec_op  = ALU_OP_W'(ALU_ADD);
    dec_ill = 1'b0;
    case (opc)
      OPC_OP: begin
        dec_a   = rs1_data;
        dec_b   = rs2_data;
        dec_op  = ALU_OP_W'({instr[30], f3});
        dec_ill = !((f7 == FUNCT7_ZERO) ||
                    ((f7 == FUNCT7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR))));
      end
      OPC_OP_IMM: begin
        dec_a  = rs1_data;
        dec_b  = XLEN'($signed(instr[31:20]));
        dec_op = ALU_OP_W'({1'b0, f3});
        if (f3 == F3_SLL) begin
          dec_b   = XLEN'(instr[24:20]);
          dec_ill = (f7 != FUNCT7_ZERO);
        end else if (f3 == F3_SR) begin
          dec_b   = XLEN'(instr[24:20]);
          dec_op  = ALU_OP_W'({instr[30], F3_SR});
          dec_ill = !((f7 == FUNCT7_ZERO) || (f7 == FUNCT7_ALT));
        end
      end
      OPC_LUI: begin
        dec_b = XLEN'($signed({instr[31:12], 12'b0}));
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal ops leave the ALU with a harmless ADD of zeros.
    if (dec_ill) begin
      dec_a  = '0;
      dec_b  = '0;
      dec_op = ALU_OP_W'(ALU_ADD);
    end
  end

  assign dec_we = !dec_ill && (rd != 5'd0);

  logic                valid_q;
  logic [XLEN-1:0]     a_q, b_q;
  logic [ALU_OP_W-1:0] op_q;
  logic [4:0]          rd_q;
  logic                we_q, ill_q;
  logic                in_ready, accept;

  assign in_ready = !bus.flush && (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      a_q     <= dec_a;
      b_q     <= dec_b;
      op_q    <= dec_op;
      rd_q    <= rd;
      we_q    <= dec_we;
      ill_q   <= dec_ill;
    end else if (bus.flush || bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.alu_operand_a = a_q;
  assign bus.alu_operand_b = b_q;
  assign bus.alu_opcode    = op_q;
  assign bus.out_rd_addr   = rd_q;
  assign bus.out_rd_we     = we_q;
  assign bus.out_illegal   = ill_q;

endmodule

// File: tb/tb_core_decode_stage.sv
// Bench for core_decode_stage: decode vector table plus handshake/flush/reset/bypass sequences.
module tb_core_decode_stage;

  logic CLOCK_50 = 1'b0;
  logic RESET;

  always #10 CLOCK_50 = ~CLOCK_50;

  core_decode_stage_if #(.XLEN(32), .ALU_OP_W(4)) bus ();

  core_decode_stage #(
    .XLEN          (32),
    .ALU_OP_W      (4),
    .REGFILE_RESET (1)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .bus      (bus.slave)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        exp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  function automatic exp_t mk(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic [4:0] rd,
                              logic we, logic ill);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.rd = rd; e.we = we; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t act;
    act = {bus.alu_operand_a, bus.alu_operand_b, bus.alu_opcode, bus.out_rd_addr,
           bus.out_rd_we, bus.out_illegal};
    if (exp_q.size() == 0) begin
      chk({tag, ".out_valid"}, 80'(bus.out_valid), 80'(1'b0));
    end else begin
      chk({tag, ".out_valid"}, 80'(bus.out_valid), 80'(1'b1));
      chk({tag, ".fields"}, 80'(act), 80'(exp_q[0]));
    end
  endtask

  // One clock: drive at negedge, check in_ready, advance model at posedge, check outputs.
  task automatic step(input string tag, input logic v, input logic [31:0] ins, input exp_t e,
                      input logic ordy, input logic fl, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
    logic exp_rdy;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.wb_en     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    #1;
    exp_rdy = !fl && ((exp_q.size() == 0) || ordy);
    chk({tag, ".in_ready"}, 80'(bus.in_ready), 80'(exp_rdy));
    @(posedge CLOCK_50);
    if ((exp_q.size() != 0) && (fl || ordy)) void'(exp_q.pop_front());
    if (v && exp_rdy) exp_q.push_back(e);
    @(negedge CLOCK_50);
    check_out(tag);
  endtask

  task automatic issue(input string tag, input logic [31:0] ins, input exp_t e);
    step(tag, 1'b1, ins, e, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic wb(input string tag, input logic [4:0] wa, input logic [31:0] wd);
    step(tag, 1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b1, wa, wd);
  endtask

  task automatic do_reset(input string tag);
    exp_t act;
    RESET = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    act = {bus.alu_operand_a, bus.alu_operand_b, bus.alu_opcode, bus.out_rd_addr,
           bus.out_rd_we, bus.out_illegal};
    chk({tag, ".out_valid"}, 80'(bus.out_valid), 80'(1'b0));
    chk({tag, ".fields"}, 80'(act), 80'(0));
    RESET = 1'b0;
    exp_q.delete();
  endtask

  localparam logic [31:0] I_ADD_2_1_1  = 32'h00108133;
  localparam logic [31:0] I_XOR_8_1_2  = 32'h0020C433;
  localparam logic [31:0] I_ADDI_6_1_M = 32'hFFF08313;
  localparam logic [31:0] I_ADD_2_1_0  = 32'h00008133;

`ifdef DECODE_BYPASS_EN
  localparam logic [31:0] BYP_A = 32'hDEADBEEF;
`else
  localparam logic [31:0] BYP_A = 32'h00000011;
`endif

  vec_t vecs[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    RESET         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;

    // Register state for the table: x1 = 5, x2 = 7.
    vecs[0]  = '{32'h402081B3, mk(32'd5, 32'd7, 4'b1000, 5'd3, 1'b1, 1'b0)};          // SUB
    vecs[1]  = '{32'h4030D213, mk(32'd5, 32'd3, 4'b1101, 5'd4, 1'b1, 1'b0)};          // SRAI
    vecs[2]  = '{32'hABCDE2B7, mk(32'd0, 32'hABCDE000, 4'b0000, 5'd5, 1'b1, 1'b0)};   // LUI
    vecs[3]  = '{32'h0000006F, mk(32'd0, 32'd0, 4'b0000, 5'd0, 1'b0, 1'b1)};          // JAL
    vecs[4]  = '{32'h4020C1B3, mk(32'd0, 32'd0, 4'b0000, 5'd3, 1'b0, 1'b1)};          // bad f7
    vecs[5]  = '{32'h00100013, mk(32'd0, 32'd1, 4'b0000, 5'd0, 1'b0, 1'b0)};          // rd=x0
    vecs[6]  = '{I_ADDI_6_1_M, mk(32'd5, 32'hFFFFFFFF, 4'b0000, 5'd6, 1'b1, 1'b0)};   // ADDI -1
    vecs[7]  = '{32'h00411393, mk(32'd7, 32'd4, 4'b0001, 5'd7, 1'b1, 1'b0)};          // SLLI
    vecs[8]  = '{32'h40411393, mk(32'd0, 32'd0, 4'b0000, 5'd7, 1'b0, 1'b1)};          // bad SLLI
    vecs[9]  = '{I_XOR_8_1_2,  mk(32'd5, 32'd7, 4'b0100, 5'd8, 1'b1, 1'b0)};          // XOR
    vecs[10] = '{32'h401154B3, mk(32'd7, 32'd5, 4'b1101, 5'd9, 1'b1, 1'b0)};          // SRA
    vecs[11] = '{32'hFFE0B513, mk(32'd5, 32'hFFFFFFFE, 4'b0011, 5'd10, 1'b1, 1'b0)};  // SLTIU
    vecs[12] = '{32'h0F017593, mk(32'd7, 32'h000000F0, 4'b0111, 5'd11, 1'b1, 1'b0)};  // ANDI

    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    do_reset("reset");
    #1;
    chk("reset.in_ready", 80'(bus.in_ready), 80'(1'b1));

    issue("addi_x1", 32'h00500093, mk(32'd0, 32'd5, 4'b0000, 5'd1, 1'b1, 1'b0));
    wb("wb_x1", 5'd1, 32'd5);
    issue("add_x2", I_ADD_2_1_1, mk(32'd5, 32'd5, 4'b0000, 5'd2, 1'b1, 1'b0));
    wb("wb_x2", 5'd2, 32'd7);

    for (int i = 0; i < 13; i++) begin
      issue($sformatf("vec%0d", i), vecs[i].instr, vecs[i].exp);
    end
    idle("vec_drain");

    // Backpressure: held output must not change and the waiting instruction is taken once.
    step("bp_load", 1'b1, I_ADD_2_1_1, mk(32'd5, 32'd5, 4'b0000, 5'd2, 1'b1, 1'b0),
         1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("bp_hold%0d", i), 1'b1, I_XOR_8_1_2, vecs[9].exp,
           1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    end
    issue("bp_rel", I_XOR_8_1_2, vecs[9].exp);
    issue("bp_next", I_ADDI_6_1_M, vecs[6].exp);
    idle("bp_drain");

    // Flush kills the held op, rejects the incoming one, but writeback still lands.
    step("fl_load", 1'b1, I_ADD_2_1_1, mk(32'd5, 32'd5, 4'b0000, 5'd2, 1'b1, 1'b0),
         1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step("fl_kill", 1'b1, I_XOR_8_1_2, vecs[9].exp, 1'b0, 1'b1, 1'b1, 5'd12, 32'h55);
    idle("fl_after");
    issue("fl_wb_x12", 32'h000606B3, mk(32'h55, 32'd0, 4'b0000, 5'd13, 1'b1, 1'b0));
    idle("fl_drain");

    step("x0_wb", 1'b1, 32'h00000733, mk(32'd0, 32'd0, 4'b0000, 5'd14, 1'b1, 1'b0),
         1'b1, 1'b0, 1'b1, 5'd0, 32'h1234);
    issue("x0_read", 32'h00000733, mk(32'd0, 32'd0, 4'b0000, 5'd14, 1'b1, 1'b0));
    idle("x0_drain");

    wb("byp_pre", 5'd1, 32'h11);
    step("byp_same", 1'b1, I_ADD_2_1_0, mk(BYP_A, 32'd0, 4'b0000, 5'd2, 1'b1, 1'b0),
         1'b1, 1'b0, 1'b1, 5'd1, 32'hDEADBEEF);
    issue("byp_after", I_ADD_2_1_0, mk(32'hDEADBEEF, 32'd0, 4'b0000, 5'd2, 1'b1, 1'b0));
    idle("byp_drain");

    // Reset while stalled with a pending instruction; register file is cleared too.
    step("rs_load", 1'b1, I_ADD_2_1_1,
         mk(32'hDEADBEEF, 32'hDEADBEEF, 4'b0000, 5'd2, 1'b1, 1'b0),
         1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step("rs_stall", 1'b1, I_XOR_8_1_2, vecs[9].exp, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    do_reset("rs_reset");
    issue("rs_rf_clear", I_ADD_2_1_1, mk(32'd0, 32'd0, 4'b0000, 5'd2, 1'b1, 1'b0));
    idle("rs_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
